// File: rtl/clock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_seq_ctrl
// Purpose  : Cascade enables and hour/minute set-mode FSM for an h:m:s chain.
// Revision : 1.0
// ============================================================================
module clock_seq_ctrl #(
    parameter int W        = 8,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic         clk_1Hz,
    input  logic         rst_n,
    input  logic         run_en,
    input  logic         mode_btn,
    input  logic         inc_btn,
    input  logic [W-1:0] sec_q,
    input  logic [W-1:0] min_q,
    input  logic [W-1:0] hour_q,
    output logic         sec_en,
    output logic         min_en,
    output logic         hour_en,
    output logic         sec_clr,
    output logic         day_tick,
    output logic [1:0]   mode,
    output logic         blink
);

    localparam logic [W-1:0] C_SEC_MAX  = W'(SEC_MAX);
    localparam logic [W-1:0] C_MIN_MAX  = W'(MIN_MAX);
    localparam logic [W-1:0] C_HOUR_MAX = W'(HOUR_MAX);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t r_state;
    logic   r_blink;
    logic   r_mode_btn_d;
    logic   r_inc_btn_d;
    logic   r_in_reset;

    logic   w_mode_rise;
    logic   w_inc_rise;
    logic   w_sec_carry;
    logic   w_min_carry;
    logic   w_sec_en;
    logic   w_min_en;
    logic   w_hour_en;
    logic   w_sec_clr;
    logic   w_day_tick;

    assign w_mode_rise = mode_btn & ~r_mode_btn_d;
    assign w_inc_rise  = inc_btn & ~r_inc_btn_d;
    assign w_sec_carry = (sec_q == C_SEC_MAX);
    assign w_min_carry = w_sec_carry & (min_q == C_MIN_MAX);

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_blink      <= 1'b0;
            r_mode_btn_d <= 1'b0;
            r_inc_btn_d  <= 1'b0;
            r_in_reset   <= 1'b1;
        end else begin
            r_in_reset   <= 1'b0;
            r_mode_btn_d <= mode_btn;
            r_inc_btn_d  <= inc_btn;
            if (w_mode_rise) begin
                r_blink <= 1'b0;
                case (r_state)
                    ST_RUN:      r_state <= ST_SET_HOUR;
                    ST_SET_HOUR: r_state <= ST_SET_MIN;
                    default:     r_state <= ST_RUN;
                endcase
            end else begin
                case (r_state)
                    ST_SET_HOUR,
                    ST_SET_MIN: r_blink <= ~r_blink;
                    ST_RUN:     r_blink <= 1'b0;
                    default: begin
                        // Unused encoding: recover to RUN.
                        r_state <= ST_RUN;
                        r_blink <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Enables act on the pre-edge state, so the counters see them on the same edge.
    always_comb begin
        w_sec_en   = 1'b0;
        w_min_en   = 1'b0;
        w_hour_en  = 1'b0;
        w_sec_clr  = 1'b0;
        w_day_tick = 1'b0;
        if (!r_in_reset) begin
            case (r_state)
                ST_SET_HOUR: w_hour_en = w_inc_rise;
                ST_SET_MIN: begin
                    w_min_en  = w_inc_rise;
                    w_sec_clr = w_mode_rise;
                end
                ST_RUN: begin
                    if (run_en) begin
                        w_sec_en   = 1'b1;
                        w_min_en   = w_sec_carry;
                        w_hour_en  = w_min_carry;
                        w_day_tick = w_min_carry & (hour_q == C_HOUR_MAX);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sec_en   = w_sec_en;
    assign min_en   = w_min_en;
    assign hour_en  = w_hour_en;
    assign sec_clr  = w_sec_clr;
    assign day_tick = w_day_tick;
    assign mode     = r_state;
    assign blink    = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_seq_ctrl
// Purpose  : Vector table plus randomized model comparison for clock_seq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_clock_seq_ctrl;

    logic       clk_1Hz = 1'b0;
    logic       rst_n, run_en, mode_btn, inc_btn;
    logic [7:0] sec_q, min_q, hour_q;
    logic       sec_en, min_en, hour_en, sec_clr, day_tick, blink;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    clock_seq_ctrl #(.W(8), .SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23)) dut (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .run_en  (run_en),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .sec_q   (sec_q),
        .min_q   (min_q),
        .hour_q  (hour_q),
        .sec_en  (sec_en),
        .min_en  (min_en),
        .hour_en (hour_en),
        .sec_clr (sec_clr),
        .day_tick(day_tick),
        .mode    (mode),
        .blink   (blink)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    // Expected output packing: {sec_en, min_en, hour_en, sec_clr, day_tick, mode[1:0], blink}
    typedef struct {
        logic       rst_n, run_en, mode_btn, inc_btn;
        logic [7:0] sec, min, hour;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic re, input logic mb, input logic ib,
                                input int s, input int m, input int h, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.run_en = re; v.mode_btn = mb; v.inc_btn = ib;
        v.sec = 8'(s); v.min = 8'(m); v.hour = 8'(h); v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {sec_en, min_en, hour_en, sec_clr, day_tick, mode, blink};
    endfunction

    // Reference model: mode index 0=RUN,1=SET_HOUR,2=SET_MIN, tracked as plain integers.
    int   m_mode;
    logic m_blink, m_mode_d, m_inc_d, m_flag;

    function automatic logic [7:0] model_expect();
        logic mr, ir, se, me, he, sc, dt;
        mr = mode_btn && !m_mode_d;
        ir = inc_btn && !m_inc_d;
        se = 0; me = 0; he = 0; sc = 0; dt = 0;
        if (!m_flag) begin
            if (m_mode == 0 && run_en) begin
                se = 1;
                me = (sec_q == 59);
                he = (sec_q == 59) && (min_q == 59);
                dt = he && (hour_q == 23);
            end else if (m_mode == 1) begin
                he = ir;
            end else if (m_mode == 2) begin
                me = ir;
                sc = mr;
            end
        end
        return {se, me, he, sc, dt, 2'(m_mode), m_blink};
    endfunction

    task automatic model_step();
        logic mr;
        mr = mode_btn && !m_mode_d;
        if (!rst_n) begin
            m_mode = 0; m_blink = 0; m_mode_d = 0; m_inc_d = 0; m_flag = 1;
        end else begin
            m_flag = 0;
            if (mr) begin
                m_mode  = (m_mode + 1) % 3;
                m_blink = 0;
            end else begin
                m_blink = (m_mode != 0) ? !m_blink : 1'b0;
            end
            m_mode_d = mode_btn;
            m_inc_d  = inc_btn;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (sec_en,min_en,hour_en,sec_clr,day_tick,mode,blink)",
                     name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        int         pick;

        rst_n = 0; run_en = 0; mode_btn = 0; inc_btn = 0;
        sec_q = 0; min_q = 0; hour_q = 0;

        //            rst re mb ib sec min hr    se me he sc dt mode blink
        tbl.push_back(mk(1, 1, 0, 0, 58, 0,  0, 8'b0_0_0_0_0_00_0)); // reset flag gates
        tbl.push_back(mk(1, 1, 0, 0, 58, 0,  0, 8'b1_0_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 59, 0,  0, 8'b1_1_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 59, 59, 23, 8'b1_1_1_0_1_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 59, 59, 22, 8'b1_1_1_0_0_00_0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 0, 0, 0, 59, 59, 23, 8'b0_0_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  0,  0, 8'b1_0_0_0_0_00_0)); // enter SET_HOUR
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(1, 1, 0, 1, 0,  0,  0, 8'b0_0_1_0_0_01_1)); // inc held 3 cycles
        tbl.push_back(mk(1, 1, 0, 1, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(1, 1, 0, 1, 0,  0,  0, 8'b0_0_0_0_0_01_1));
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(1, 1, 0, 1, 0,  0,  0, 8'b0_0_1_0_0_01_1));
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(1, 1, 0, 1, 0,  0,  0, 8'b0_0_1_0_0_01_1));
        tbl.push_back(mk(1, 1, 1, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0)); // to SET_MIN
        tbl.push_back(mk(1, 1, 1, 1, 0,  59, 0, 8'b0_1_0_0_0_10_0)); // minute inc, no hour carry
        tbl.push_back(mk(1, 1, 0, 0, 0,  59, 0, 8'b0_0_0_0_0_10_1));
        tbl.push_back(mk(1, 1, 1, 0, 37, 0,  0, 8'b0_0_0_1_0_10_0)); // sec_clr on exit
        tbl.push_back(mk(1, 1, 1, 0, 0,  0,  0, 8'b1_0_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b1_0_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  0,  0, 8'b1_0_0_0_0_00_0)); // to SET_HOUR
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(0, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_1)); // reset mid-set
        tbl.push_back(mk(1, 1, 0, 0, 59, 59, 23, 8'b0_0_0_0_0_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 59, 59, 23, 8'b1_1_1_0_1_00_0));
        tbl.push_back(mk(1, 1, 0, 0, 60, 59, 23, 8'b1_0_0_0_0_00_0)); // out of range: no carry
        tbl.push_back(mk(1, 1, 1, 0, 59, 59, 5,  8'b1_1_1_0_0_00_0)); // carries while leaving RUN
        tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 8'b0_0_0_0_0_01_0));
        tbl.push_back(mk(1, 1, 1, 1, 0,  0,  0, 8'b0_0_1_0_0_01_1)); // mode+inc together
        tbl.push_back(mk(1, 1, 1, 1, 0,  0,  0, 8'b0_0_0_0_0_10_0));

        repeat (2) @(posedge clk_1Hz);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; run_en = tbl[i].run_en;
            mode_btn = tbl[i].mode_btn; inc_btn = tbl[i].inc_btn;
            sec_q = tbl[i].sec; min_q = tbl[i].min; hour_q = tbl[i].hour;
            @(negedge clk_1Hz);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
            @(posedge clk_1Hz);
            #1;
        end

        // Randomized phase; the first cycle is a reset that aligns model and DUT.
        m_mode = 0; m_blink = 0; m_mode_d = 0; m_inc_d = 0; m_flag = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n  = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            run_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 2) == 0) inc_btn = ~inc_btn;
            pick = $urandom_range(0, 3);
            sec_q  = (pick == 0) ? 8'd59 : (pick == 1) ? 8'(58 + $urandom_range(0, 3))
                                         : 8'($urandom_range(0, 59));
            min_q  = ($urandom_range(0, 1) != 0) ? 8'd59 : 8'($urandom_range(0, 60));
            hour_q = ($urandom_range(0, 1) != 0) ? 8'd23 : 8'($urandom_range(0, 24));
            e = model_expect();
            @(negedge clk_1Hz);
            if (i != 0) check($sformatf("rand%0d", i), dut_out(), e);
            model_step();
            @(posedge clk_1Hz);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
